// File: rtl/arm7tdmi_mem_arb.sv
// Arbitrates ARM7TDMI instruction-fetch and data requests onto a single memory port,
// one transfer at a time, with a starvation counter that eventually forces a fetch.
module arm7tdmi_mem_arb #(
    parameter int unsigned MAX_FETCH_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam int unsigned CntW = (MAX_FETCH_WAIT < 1) ? 1 : $clog2(MAX_FETCH_WAIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_FETCH_WAIT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

    state_e          state_q;
    logic [CntW-1:0] wait_cnt_q;
    logic            fetch_prio;

    // Grants are combinational so a requester can be accepted in the same IDLE cycle.
    always_comb begin
        fetch_prio = if_req && (wait_cnt_q >= CntMax);
        d_gnt      = rst_n && (state_q == IDLE) && d_req && !fetch_prio;
        if_gnt     = rst_n && (state_q == IDLE) && if_req && !d_gnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (d_gnt) begin
                        mem_addr  <= d_addr;
                        mem_be    <= d_be;
                        mem_wdata <= d_wdata;
                        mem_we    <= d_we;
                        mem_re    <= ~d_we;
                        state_q   <= BUSY_D;
                        if (if_req && (wait_cnt_q < CntMax)) begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
                    end else if (if_gnt) begin
                        // Word-align the fetch address; the low bits are never driven out.
                        mem_addr   <= if_addr & 32'hFFFF_FFFC;
                        mem_be     <= 4'hF;
                        mem_we     <= 1'b0;
                        mem_re     <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= BUSY_IF;
                    end
                end
                BUSY_IF: begin
                    if (mem_ready) begin
                        mem_re   <= 1'b0;
                        if_valid <= 1'b1;
                        if_rdata <= mem_rdata;
                        state_q  <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (mem_ready) begin
                        mem_re  <= 1'b0;
                        mem_we  <= 1'b0;
                        d_valid <= 1'b1;
                        if (!mem_we) begin
                            d_rdata <= mem_rdata;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arm7tdmi_mem_arb.sv
// Directed bench for arm7tdmi_mem_arb: reset, fetch, data read/write, arbitration and
// starvation override, and reset abort of a stalled transfer.
module tb_arm7tdmi_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arm7tdmi_mem_arb #(.MAX_FETCH_WAIT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_valid   (d_valid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
        tick();
        tick();
        // Grants suppressed while reset is asserted.
        if_req = 1'b1; d_req = 1'b1;
        #1;
        check("rst_if_gnt", 32'(if_gnt), 32'd0);
        check("rst_d_gnt", 32'(d_gnt), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        if_req = 1'b0; d_req = 1'b0; rst_n = 1'b1;
        tick();

        // Single fetch, unaligned address, ready already high.
        if_req = 1'b1; if_addr = 32'h0000_0006; mem_ready = 1'b1; mem_rdata = 32'hE3A0_1005;
        #1;
        check("f_if_gnt", 32'(if_gnt), 32'd1);
        check("f_d_gnt", 32'(d_gnt), 32'd0);
        tick();
        if_req = 1'b0;
        #1;
        check("f_mem_addr", mem_addr, 32'h4);
        check("f_mem_be", 32'(mem_be), 32'hF);
        check("f_mem_re", 32'(mem_re), 32'd1);
        check("f_mem_we", 32'(mem_we), 32'd0);
        check("f_busy_no_gnt", 32'(if_gnt), 32'd0);
        check("f_no_valid_yet", 32'(if_valid), 32'd0);
        tick();
        check("f_if_valid", 32'(if_valid), 32'd1);
        check("f_if_rdata", if_rdata, 32'hE3A0_1005);
        check("f_mem_re_off", 32'(mem_re), 32'd0);
        tick();
        check("f_valid_pulse", 32'(if_valid), 32'd0);

        // Simultaneous requests with a clear wait counter: data first, then fetch.
        if_req = 1'b1; if_addr = 32'h0000_1003; d_req = 1'b1; d_we = 1'b0;
        d_addr = 32'h0000_0200; d_be = 4'hF; mem_rdata = 32'h1234_5678;
        #1;
        check("arb_d_gnt", 32'(d_gnt), 32'd1);
        check("arb_if_gnt", 32'(if_gnt), 32'd0);
        tick();
        d_req = 1'b0;
        #1;
        check("arb_mem_addr_d", mem_addr, 32'h200);
        check("arb_mem_re_d", 32'(mem_re), 32'd1);
        check("arb_busy_if_gnt", 32'(if_gnt), 32'd0);
        tick();
        check("arb_d_valid", 32'(d_valid), 32'd1);
        check("arb_d_rdata", d_rdata, 32'h1234_5678);
        check("arb_if_gnt_next", 32'(if_gnt), 32'd1);
        tick();
        if_req = 1'b0;
        #1;
        check("arb_mem_addr_f", mem_addr, 32'h1000);
        tick();
        check("arb_if_valid", 32'(if_valid), 32'd1);
        tick();

        // Starvation: four data grants, then fetch wins, then data wins again.
        if_req = 1'b1; d_req = 1'b1; if_addr = 32'h0000_2000; mem_rdata = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("starve_d_gnt%0d", i), 32'(d_gnt), 32'd1);
            tick();
            tick();
        end
        #1;
        check("starve_if_gnt", 32'(if_gnt), 32'd1);
        check("starve_d_blocked", 32'(d_gnt), 32'd0);
        tick();
        check("starve_mem_addr", mem_addr, 32'h2000);
        tick();
        check("starve_if_valid", 32'(if_valid), 32'd1);
        check("starve_cnt_cleared", 32'(d_gnt), 32'd1);
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // Data write held off by mem_ready for three cycles.
        mem_ready = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100;
        d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h5555_AAAA;
        #1;
        check("wr_d_gnt", 32'(d_gnt), 32'd1);
        tick();
        d_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wr_we%0d", i), 32'(mem_we), 32'd1);
            check($sformatf("wr_re%0d", i), 32'(mem_re), 32'd0);
            check($sformatf("wr_addr%0d", i), mem_addr, 32'h100);
            check($sformatf("wr_be%0d", i), 32'(mem_be), 32'h3);
            check($sformatf("wr_wdata%0d", i), mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("wr_no_valid%0d", i), 32'(d_valid), 32'd0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("wr_we_last", 32'(mem_we), 32'd1);
        tick();
        check("wr_d_valid", 32'(d_valid), 32'd1);
        check("wr_we_off", 32'(mem_we), 32'd0);
        check("wr_rdata_kept", d_rdata, 32'hCAFE_0001);
        tick();
        check("wr_valid_pulse", 32'(d_valid), 32'd0);
        check("wr_addr_held", mem_addr, 32'h100);
        check("wr_be_held", 32'(mem_be), 32'h3);

        // Reset in the middle of a stalled write.
        mem_ready = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0300;
        d_wdata = 32'h0BAD_F00D; d_be = 4'hF;
        tick();
        d_req = 1'b0;
        #1;
        check("abort_we_busy", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_d_valid", 32'(d_valid), 32'd0);
        check("abort_addr", mem_addr, 32'h0);
        check("abort_wdata", mem_wdata, 32'h0);
        check("abort_be", 32'(mem_be), 32'h0);
        check("abort_d_rdata", d_rdata, 32'h0);
        check("abort_if_rdata", if_rdata, 32'h0);
        rst_n = 1'b1; mem_ready = 1'b1;
        tick();
        check("abort_no_pulse", 32'(d_valid), 32'd0);
        check("idle_ready_ignored", 32'(mem_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
